// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data memory) in front of one shared
// memory port: registered launch, bounded wait for mem_done, sticky error flag.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_dm_q, last_dm_d;
  logic        mem_en_d, mem_wr_d;
  logic [15:0] mem_addr_d, mem_wdata_d;
  logic [15:0] if_rdata_d, dm_rdata_d;
  logic        if_done_d, dm_done_d;
  logic        err_d;

  logic        if_pend, dm_pend, grant_dm;

  // A side whose done is high this cycle has already been served; its
  // still-high request must not win arbitration again.
  assign if_pend  = if_req && !if_done;
  assign dm_pend  = dm_req && !dm_done;
  assign if_stall = if_pend;
  assign dm_stall = dm_pend;

  // DM wins a tie unless it was granted last time.
  assign grant_dm = dm_pend && (!if_pend || !last_dm_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = err;

    case (state_q)
      IDLE: begin
        if (mem_done) begin
          err_d = 1'b1;
        end
        if (grant_dm) begin
          state_d     = BUSY_DM;
          mem_en_d    = 1'b1;
          mem_wr_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          cnt_d       = 4'd1;
          last_dm_d   = 1'b1;
        end else if (if_pend) begin
          state_d    = BUSY_IF;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = if_addr;
          cnt_d      = 4'd1;
          last_dm_d  = 1'b0;
        end
      end

      BUSY_IF, BUSY_DM: begin
        // mem_done has priority: a response in the TIMEOUT-th cycle still counts.
        if (mem_done || cnt_q == TIMEOUT_CNT) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (!mem_done) begin
            err_d = 1'b1;
          end
          if (state_q == BUSY_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_done ? mem_rdata : 16'h0000;
          end else begin
            dm_done_d = 1'b1;
            if (!mem_wr) begin
              dm_rdata_d = mem_done ? mem_rdata : 16'h0000;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_dm_q <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      if_rdata  <= 16'h0000;
      dm_rdata  <= 16'h0000;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_dm_q <= last_dm_d;
      mem_en    <= mem_en_d;
      mem_wr    <= mem_wr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_done   <= if_done_d;
      dm_done   <= dm_done_d;
      err       <= err_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max BUSY cycles awaiting mem_done before abort (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port if_req, input, 1, fetch-side read request; held high until if_done.
REQ-005 SHALL have port if_addr, input, 16, fetch address; stable while if_req high.
REQ-006 SHALL have port if_rdata, output, 16, fetch read data; valid when if_done high.
REQ-007 SHALL have port if_done, output, 1, one-cycle fetch completion pulse.
REQ-008 SHALL have port if_stall, output, 1, fetch stall: if_req AND NOT if_done (combinational).
REQ-009 SHALL have ports dm_req/dm_wr (input, 1), dm_addr/dm_wdata (input, 16), meaning data-side request, write flag, address, write data; all stable while dm_req high.
REQ-010 SHALL have ports dm_rdata (output, 16), dm_done (output, 1) and dm_stall (output, 1), with the same meaning as the fetch-side equivalents.
REQ-011 SHALL have ports mem_en, mem_wr (output, 1) and mem_addr, mem_wdata (output, 16), meaning shared memory launch strobe, write flag, address and write data.
REQ-012 SHALL have ports mem_rdata (input, 16) and mem_done (input, 1), meaning memory read data and the completion strobe.
REQ-013 SHALL have port err, output, 1, sticky protocol/timeout error.

Function
REQ-014 SHALL implement states IDLE, BUSY_IF, BUSY_DM.
REQ-015 IDLE with a pending eligible request SHALL grant on that edge and latch the address, write data and write flag into registers driving mem_*.
REQ-016 Arbitration SHALL favour DM when only DM requests, IF when only IF requests; when both request, grant DM unless the previous grant was DM, then grant IF.
REQ-017 mem_en SHALL be high for exactly the first BUSY cycle (launch); mem_addr/mem_wr/mem_wdata SHALL stay stable for the whole BUSY period.
REQ-018 In BUSY, mem_done (sampled from the launch cycle onward) SHALL capture mem_rdata into the granted side's rdata register, pulse that side's done on the next cycle, and return to IDLE.
REQ-019 Minimum latency: req at cycle 0 -> mem_en at cycle 1 -> mem_done at cycle 1 -> done at cycle 2.
REQ-020 In the cycle a side's done is high, its req SHALL be ignored for arbitration; the other side may be granted in that cycle.
REQ-021 For a DM write, dm_rdata SHALL be left unchanged; dm_done SHALL still pulse.
REQ-022 A 4-bit BUSY counter SHALL load 1 at launch and increment each BUSY cycle; if it equals TIMEOUT with mem_done low, the block SHALL set err, pulse the granted done with rdata 16'h0000, and return to IDLE.
REQ-023 mem_done high while IDLE SHALL set err and be otherwise ignored.
REQ-024 err SHALL remain high until rst; arbitration SHALL continue normally after err.
REQ-025 Request drop before done is illegal; the block SHALL complete the launched access regardless.

Reset
REQ-026 rst high SHALL immediately force IDLE with mem_en, mem_wr, if_done, dm_done and err at 0, the mem_addr, mem_wdata, if_rdata and dm_rdata registers at 16'h0000, the counter at 0 and the last-grant flag at IF.
REQ-027 rst asserted mid-access SHALL abort the access without a done pulse; the first grant after release follows REQ-016.

Verification
REQ-028 Single fetch: if_req=1, if_addr=16'h0040; mem_done=1 with rdata=16'hA5A5 in the launch cycle -> mem_en at cycle 1 with mem_addr=16'h0040, if_done and if_rdata=16'hA5A5 at cycle 2.
REQ-029 Simultaneous if_req and dm_req after reset -> DM granted first; IF granted in the cycle dm_done pulses; subsequent simultaneous requests alternate.
REQ-030 DM write dm_addr=16'h0100, dm_wdata=16'h1234, mem_done 3 cycles after launch -> mem_wr=1 for all BUSY cycles, dm_rdata unchanged, dm_stall high until dm_done.
REQ-031 TIMEOUT=4 with mem_done never asserted -> err rises with a done pulse carrying rdata 16'h0000 at the expected cycle, state returns to IDLE, and the next request is served normally with err still 1.
REQ-032 Spurious mem_done in IDLE sets err=1; rst asserted during BUSY_IF -> outputs at reset values asynchronously and no if_done pulse.
